// File: rtl/md_unit.sv
// Multiply/divide unit for the execute stage: fixed-latency MULT/DIV with
// architectural HI/LO registers and a busy flag for the hazard unit.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic               pend_wr_q, pend_wr_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  logic               div_zero;
  logic [31:0]        div_safe;
  logic signed [63:0] s_a, s_b, s_div;
  logic [63:0]        mul_s, mul_u, div_s, div_u;

  // Divisor forced non-zero so the dividers never see zero; the result is discarded then.
  assign div_zero = (in1 == 32'd0);
  assign div_safe = div_zero ? 32'd1 : in1;

  // 64-bit signed domain keeps 0x80000000 / -1 from overflowing.
  assign s_a   = 64'($signed(in0));
  assign s_b   = 64'($signed(in1));
  assign s_div = 64'($signed(div_safe));
  assign mul_s = 64'(s_a * s_b);
  assign mul_u = 64'(in0) * 64'(in1);
  assign div_s = {32'(s_a % s_div), 32'(s_a / s_div)};
  assign div_u = {in0 % div_safe, in0 / div_safe};

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Accept in idle, count down while busy, retire pending result on the last busy edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (md_op)
            OP_MULT: begin
              pend_d    = mul_s;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES - 1);
              state_d   = ST_BUSY;
            end
            OP_MULTU: begin
              pend_d    = mul_u;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES - 1);
              state_d   = ST_BUSY;
            end
            OP_DIV: begin
              pend_d    = div_s;
              pend_wr_d = !div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES - 1);
              state_d   = ST_BUSY;
            end
            OP_DIVU: begin
              pend_d    = div_u;
              pend_wr_d = !div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES - 1);
              state_d   = ST_BUSY;
            end
            OP_MTHI: hi_d = in0;
            OP_MTLO: lo_d = in0;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes model results, a negedge monitor
// pops them when the unit retires an operation.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] in0 = 32'd0;
  logic [31:0] in1 = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .md_op(md_op),
    .in0(in0), .in1(in1), .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural MIPS semantics in plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] cur_hi,
                                            input logic [31:0] cur_lo);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    res = {cur_hi, cur_lo};
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      3'd0: res = sa * sbv;
      3'd1: res = ua * ub;
      3'd2: if (b != 32'd0) begin
        q   = sa / sbv;
        r   = sa - q * sbv;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 32'd0) begin
        uq  = ua / ub;
        ur  = ua - uq * ub;
        res = {ur[31:0], uq[31:0]};
      end
      3'd4: res[63:32] = a;
      3'd5: res[31:0]  = a;
      default: ;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called and returns at posedge+1; waits for idle, then issues one op for one edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          guard;
    logic [63:0] r;
    exp_t        e;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_wait actual=busy_stuck required=idle");
    end
    r        = ref_model(op, a, b, m_hi, m_lo);
    e.op     = op;
    e.exp_hi = r[63:32];
    e.exp_lo = r[31:0];
    e.old_hi = m_hi;
    e.old_lo = m_lo;
    e.cycles = (op < 3'd2) ? 5 : 10;
    sb.push_back(e);
    m_hi     = r[63:32];
    m_lo     = r[31:0];
    op_valid = 1'b1;
    md_op    = op;
    in0      = a;
    in1      = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    md_op    = 3'($urandom);
    in0      = $urandom;
    in1      = $urandom;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=busy_stuck required=idle");
    end
  endtask

  // Monitor: retires immediate ops one cycle after accept, mult/div when busy falls.
  logic imm_due = 1'b0;
  logic in_busy = 1'b0;
  int   bcnt = 0;
  exp_t me;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
      imm_due = 1'b0;
      in_busy = 1'b0;
      bcnt    = 0;
    end else begin
      if (imm_due) begin
        imm_due = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL imm_empty actual=no_entry required=entry");
        end else begin
          me = sb.pop_front();
          check("imm_hi", hi, me.exp_hi);
          check("imm_lo", lo, me.exp_lo);
          check("imm_busy", 32'(busy), 32'd0);
        end
      end
      if (in_busy) begin
        if (busy) begin
          bcnt++;
          if (sb.size() != 0) begin
            check("hold_hi", hi, sb[0].old_hi);
            check("hold_lo", lo, sb[0].old_lo);
          end
          if (bcnt > 12) begin
            checks++;
            errors++;
            $display("FAIL busy_len actual=%0d required<=10", bcnt);
            in_busy = 1'b0;
          end
        end else begin
          in_busy = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL md_empty actual=no_entry required=entry");
          end else begin
            me = sb.pop_front();
            check("md_hi", hi, me.exp_hi);
            check("md_lo", lo, me.exp_lo);
            check("busy_len", 32'(bcnt), 32'(me.cycles));
          end
        end
      end
      if (op_valid && !busy) begin
        if (md_op >= 3'd4) imm_due = 1'b1;
        else begin
          in_busy = 1'b1;
          bcnt    = 0;
        end
      end
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle();
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);

    issue(3'd4, 32'h1234_5678, 32'd0);
    issue(3'd3, 32'd7, 32'd0);
    wait_idle();
    check("divz_hi", hi, 32'h1234_5678);
    check("divz_lo", lo, 32'hFFFF_FFFD);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_lo", lo, 32'h8000_0000);

    // MTLO driven during busy must be dropped.
    issue(3'd0, 32'd2, 32'd3);
    @(posedge clk); #1;
    op_valid = 1'b1;
    md_op    = 3'd5;
    in0      = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    op_valid = 1'b0;
    wait_idle();
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd6);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    check("b2b_lo", lo, 32'hDEAD_BEEF);
    check("b2b_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a divide.
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    issue(3'd4, 32'hAAAA_0000, 32'd0);
    issue(3'd5, 32'h0000_BBBB, 32'd0);
    check("mt_hi", hi, 32'hAAAA_0000);
    check("mt_lo", lo, 32'h0000_BBBB);
    issue(3'd7, 32'h1111_1111, 32'h2222_2222);
    issue(3'd6, 32'h3333_3333, 32'h4444_4444);
    check("rsv_hi", hi, 32'hAAAA_0000);
    check("rsv_lo", lo, 32'h0000_BBBB);

    repeat (60) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);
    check("drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
